// File: rtl/hamming74_pkg.sv
// ============================================================================
// hamming74_pkg : Hamming(7,4) shared constants, FSM state type and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package hamming74_pkg;

  localparam int CW_WIDTH = 7;

  // Codeword positions (1-based); bit (POS-1) of a codeword vector
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P3 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

  localparam logic [2:0] LAST_IDX = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  function automatic logic [CW_WIDTH-1:0] hamming74_encode(input logic [3:0] d);
    logic [CW_WIDTH-1:0] cw;
    cw             = '0;
    cw[POS_P1-1]   = d[0] ^ d[1] ^ d[3];
    cw[POS_P2-1]   = d[0] ^ d[2] ^ d[3];
    cw[POS_D1-1]   = d[0];
    cw[POS_P3-1]   = d[1] ^ d[2] ^ d[3];
    cw[POS_D2-1]   = d[1];
    cw[POS_D3-1]   = d[2];
    cw[POS_D4-1]   = d[3];
    return cw;
  endfunction

  // Decoder side: syndrome equals the 1-based position of a single-bit error
  function automatic logic [2:0] hamming74_syndrome(input logic [CW_WIDTH-1:0] cw);
    logic [2:0] s;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return s;
  endfunction

  function automatic logic [CW_WIDTH-1:0] hamming74_err_mask(input logic [2:0] pos);
    logic [CW_WIDTH-1:0] m;
    m = '0;
    if (pos != 3'd0) m[pos - 3'd1] = 1'b1;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming74_enc_core.sv
// ============================================================================
// hamming74_enc_core : combinational nibble -> 7-bit Hamming codeword
// Rev 1.0
// ============================================================================
`default_nettype none

module hamming74_enc_core
  import hamming74_pkg::*;
(
  input  logic [3:0]          data,
  output logic [CW_WIDTH-1:0] codeword
);

  assign codeword = hamming74_encode(data);

endmodule

`default_nettype wire

// File: rtl/hamming_encoder_74_tx.sv
// ============================================================================
// hamming_encoder_74_tx : serial Hamming(7,4) transmitter, position 1 first.
// Optional error injection via macro HAMMING_ENC_ERR_INJECT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hamming_encoder_74_tx
  import hamming74_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       in_valid,
`ifdef HAMMING_ENC_ERR_INJECT_EN
  input  logic [2:0] err_pos,
`endif
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_active,
  output logic       frame_start,
  output logic [2:0] bit_idx
);

  tx_state_e           state_q, state_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [CW_WIDTH-1:0] cw_q, cw_d;
  logic [CW_WIDTH-1:0] enc_cw;
  logic [CW_WIDTH-1:0] err_mask;
  logic                last_bit;
  logic                accept;

  hamming74_enc_core u_core (
    .data     (data_in),
    .codeword (enc_cw)
  );

`ifdef HAMMING_ENC_ERR_INJECT_EN
  assign err_mask = hamming74_err_mask(err_pos);
`else
  assign err_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      cw_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cw_q      <= cw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cw_d      = cw_q;
    last_bit  = (state_q == ST_SEND) && (bit_idx_q == LAST_IDX);
    // rst_n gates in_ready so it drops the instant reset asserts
    in_ready  = rst_n && ena && ((state_q == ST_IDLE) || last_bit);
    accept    = in_valid && in_ready;

    if (ena) begin
      if (accept) begin
        state_d   = ST_SEND;
        bit_idx_d = '0;
        cw_d      = enc_cw ^ err_mask;
      end else if (state_q == ST_SEND) begin
        if (last_bit) begin
          state_d   = ST_IDLE;
          bit_idx_d = '0;
          cw_d      = '0;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
    end
  end

  assign tx_active   = (state_q == ST_SEND);
  assign tx_bit      = tx_active && cw_q[bit_idx_q];
  assign bit_idx     = bit_idx_q;
  assign frame_start = tx_active && (bit_idx_q == 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_hamming_encoder_74_tx.sv
// ============================================================================
// tb_hamming_encoder_74_tx : randomized + directed bench with queue reference
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hamming_encoder_74_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] data_in;
  logic       in_valid;
  logic [2:0] ep_drv;
  logic       in_ready;
  logic       tx_bit;
  logic       tx_active;
  logic       frame_start;
  logic [2:0] bit_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_encoder_74_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data_in     (data_in),
    .in_valid    (in_valid),
`ifdef HAMMING_ENC_ERR_INJECT_EN
    .err_pos     (ep_drv),
`endif
    .in_ready    (in_ready),
    .tx_bit      (tx_bit),
    .tx_active   (tx_active),
    .frame_start (frame_start),
    .bit_idx     (bit_idx)
  );

  typedef struct {
    logic       b;
    logic [2:0] idx;
  } exp_t;

  exp_t       pend[$];
  logic [6:0] rx_cw;
  logic [6:0] last_frame;
  int         frames_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference codeword: data fills non-power-of-two positions in order,
  // each parity position 2^j covers every position with bit j set.
  function automatic logic [6:0] ref_cw(input logic [3:0] d, input logic [2:0] ep);
    logic [7:0] w;
    int         di;
    w  = '0;
    di = 0;
    for (int p = 1; p <= 7; p++)
      if ((p & (p - 1)) != 0) begin
        w[p] = d[di];
        di++;
      end
    for (int j = 0; j < 3; j++)
      for (int p = 1; p <= 7; p++)
        if (p != (1 << j) && ((p >> j) & 1) == 1) w[1 << j] = w[1 << j] ^ w[p];
    if (ep != 3'd0) w[ep] = ~w[ep];
    return w[7:1];
  endfunction

  // One clock cycle: drive, check presented outputs, advance model at posedge.
  task automatic cycle(input logic e, input logic v, input logic [3:0] d, input logic [2:0] ep);
    logic       exp_act;
    logic       rdy;
    logic [6:0] cw;
    exp_t       ent;
    ena      = e;
    in_valid = v;
    data_in  = d;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    ep_drv   = ep;
`else
    ep_drv   = 3'd0;
`endif
    #1;
    exp_act = (pend.size() > 0);
    rdy     = e && (pend.size() <= 1);
    check("tx_active",   32'(tx_active),   32'(exp_act));
    check("tx_bit",      32'(tx_bit),      exp_act ? 32'(pend[0].b) : 32'd0);
    check("bit_idx",     32'(bit_idx),     exp_act ? 32'(pend[0].idx) : 32'd0);
    check("frame_start", 32'(frame_start), 32'(exp_act && pend[0].idx == 3'd0));
    check("in_ready",    32'(in_ready),    32'(rdy));
    if (tx_active) begin
      rx_cw[bit_idx] = tx_bit;
      if (bit_idx == 3'd6 && e) begin
        last_frame = rx_cw;
        frames_done++;
      end
    end
    @(posedge clk);
    if (e) begin
      if (pend.size() > 0) void'(pend.pop_front());
      if (v && rdy) begin
        cw = ref_cw(d, ep_drv);
        for (int k = 0; k < 7; k++) begin
          ent.b   = cw[k];
          ent.idx = 3'(k);
          pend.push_back(ent);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 3'd0);
  endtask

  logic [2:0] syn;
  logic [6:0] fixed;
  int         hit;

  initial begin
    rst_n       = 1'b0;
    ena         = 1'b0;
    in_valid    = 1'b0;
    data_in     = 4'h0;
    ep_drv      = 3'd0;
    rx_cw       = '0;
    last_frame  = '0;
    frames_done = 0;

    @(negedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),    32'd0);
    check("rst_tx_active", 32'(tx_active),   32'd0);
    check("rst_tx_bit",    32'(tx_bit),      32'd0);
    check("rst_bit_idx",   32'(bit_idx),     32'd0);
    check("rst_fstart",    32'(frame_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 1011 from IDLE
    cycle(1'b1, 1'b1, 4'b1011, 3'd0);
    idle_cycles(8);
    check("frame_1011", 32'(last_frame), 32'(7'b1010101));

    // 0001 then 1111 back-to-back, second accepted at bit_idx 6
    cycle(1'b1, 1'b1, 4'b0001, 3'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'hF, 3'd0);
    cycle(1'b1, 1'b1, 4'b1111, 3'd0);
    check("frame_0001", 32'(last_frame), 32'(7'b0000111));
    idle_cycles(8);
    check("frame_1111", 32'(last_frame), 32'(7'b1111111));

    // in_valid held with changing data; only in_ready-cycle nibbles go out
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 4'($urandom), 3'd0);
    idle_cycles(8);

    // ena low for 3 cycles while bit_idx 2 is presented
    cycle(1'b1, 1'b1, 4'b0110, 3'd0);
    cycle(1'b1, 1'b0, 4'h0, 3'd0);
    cycle(1'b1, 1'b0, 4'h0, 3'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h9, 3'd0);
    idle_cycles(6);
    check("frame_ena_gap", 32'(last_frame), 32'(ref_cw(4'b0110, 3'd0)));

    // Reset mid-frame at bit_idx 3
    cycle(1'b1, 1'b1, 4'b1101, 3'd0);
    hit = 0;
    for (int i = 0; i < 10 && hit == 0; i++) begin
      if (pend.size() > 0 && pend[0].idx == 3'd3) hit = 1;
      else cycle(1'b1, 1'b0, 4'h0, 3'd0);
    end
    check("reach_idx3", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_active", 32'(tx_active),   32'd0);
    check("arst_tx_bit",    32'(tx_bit),      32'd0);
    check("arst_bit_idx",   32'(bit_idx),     32'd0);
    check("arst_fstart",    32'(frame_start), 32'd0);
    check("arst_in_ready",  32'(in_ready),    32'd0);
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(8);

`ifdef HAMMING_ENC_ERR_INJECT_EN
    cycle(1'b1, 1'b1, 4'b1011, 3'd3);
    idle_cycles(8);
    check("frame_err3", 32'(last_frame), 32'(7'b1010001));
    syn = 3'd0;
    for (int p = 1; p <= 7; p++) if (last_frame[p-1]) syn = syn ^ 3'(p);
    fixed = last_frame;
    if (syn != 3'd0) fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
    check("loop_syndrome", 32'(syn), 32'd3);
    check("loop_data", 32'({fixed[6], fixed[5], fixed[4], fixed[2]}), 32'(4'b1011));
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) != 0), 1'($urandom), 4'($urandom), 3'($urandom));
    idle_cycles(8);
    check("frames_seen_nonzero", 32'(frames_done > 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming_encoder_74_tx.md
HAMMING_ENCODER_74_TX -- requirements
Module: hamming_encoder_74_tx

Interface
REQ-001 SHALL have the following ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  global enable; when low, all state holds.
- data_in  in  4  nibble to encode; data_in[0]=d1 .. data_in[3]=d4.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block can accept a nibble this cycle.
- tx_bit  out  1  serial codeword bit.
- tx_active  out  1  tx_bit carries a codeword bit.
- frame_start  out  1  high with the first codeword bit only.
- bit_idx  out  3  debug: index (0..6) of the current codeword bit.
REQ-002 SHALL have one clock domain; reset is asynchronous and active-low, with ports named clk and rst_n.

Function
REQ-003 SHALL compute p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
REQ-004 SHALL form codeword positions 1..7 = p1,p2,d1,p3,d2,d3,d4.
REQ-005 SHALL transmit position 1 first and position 7 last, one bit per enabled cycle.
REQ-006 SHALL implement a two-state FSM:
- IDLE->SEND on accept (in_valid && in_ready && ena).
- SEND->IDLE after bit_idx==6 unless a new accept occurs in that same cycle.
REQ-007 SHALL drive in_ready high in IDLE, and in SEND only when bit_idx==6; otherwise low.
REQ-008 SHALL register the codeword at accept; accept at cycle N puts position 1 on tx_bit at N+1 and position 7 at N+7.
REQ-009 SHALL, on accept in the bit_idx==6 cycle, present the next frame's position 1 on the immediately following cycle (no gap).
REQ-010 SHALL assert frame_start for exactly one cycle, coincident with bit_idx==0 and tx_active.
REQ-011 SHALL hold tx_bit=0, tx_active=0 and bit_idx=0 in IDLE.
REQ-012 SHALL ignore data_in whenever in_ready is low; a held nibble is not re-sent unless re-accepted.
REQ-013 SHALL freeze the FSM, bit_idx and tx_bit while ena=0, resuming without loss when ena returns high; in_ready is low while ena=0.

Reset
REQ-014 SHALL, on rst_n low, immediately force IDLE with tx_bit=0, tx_active=0, frame_start=0, bit_idx=0 and in_ready=0 (in_ready=1 after release), aborting any frame in progress.
REQ-015 SHALL not resume an aborted frame after reset release.

Configuration
REQ-016 SHALL support macro HAMMING_ENC_ERR_INJECT_EN; when defined:
- adds input err_pos[2:0], sampled at accept.
- err_pos 1..7 inverts that codeword position in the transmitted frame.
- err_pos 0 injects nothing.
REQ-017 SHALL, when HAMMING_ENC_ERR_INJECT_EN is undefined, omit err_pos and always transmit the clean codeword.

Structure
REQ-018 SHALL place in a shared package hamming74_pkg: codeword width constant (7), position constants, the FSM state typedef, and the parity/codeword function shared with the decoder.
REQ-019 SHALL use one combinational sub-module, hamming74_enc_core (nibble -> 7-bit codeword); the shift/count/FSM logic stays in the top.

Verification
REQ-020 SHALL cover data_in=4'b1011 accepted from IDLE -> tx_bit 1,0,1,0,1,0,1 on the next 7 cycles, frame_start on the first only, bit_idx 0..6.
REQ-021 SHALL cover 4'b0001 then 4'b1111 back-to-back (second accepted at bit_idx==6) -> 1,1,1,0,0,0,0 then 1,1,1,1,1,1,1 over 14 contiguous tx_active cycles.
REQ-022 SHALL cover in_valid held high during a frame with changing data_in -> only the nibbles present at in_ready cycles are sent.
REQ-023 SHALL cover rst_n low at bit_idx==3 -> outputs zero within the same cycle; after release in_ready=1 and no residual bits.
REQ-024 SHALL cover ena low for 3 cycles at bit_idx==2 -> tx_bit and bit_idx hold, and the frame completes intact.
REQ-025 SHALL, with HAMMING_ENC_ERR_INJECT_EN, cover 4'b1011 with err_pos=3 -> 1,0,0,0,1,0,1, and a loopback check that the decoder reports syndrome 3 and corrected data 4'b1011.
